// File: rtl/opgen_queue_pkg.sv
// Shared encodings for the fetch-to-issue decode buffer: opgen codes, bus
// widths, MIPS opcode/funct/regimm fields and a lane PC helper.
package opgen_queue_pkg;

  // opgen codes
  localparam int OPGEN_WIDTH = 6;

  typedef enum logic [OPGEN_WIDTH-1:0] {
    OPGEN_NOP = '0,
    OPGEN_ADD,
    OPGEN_SUB,
    OPGEN_SLT,
    OPGEN_SLTU,
    OPGEN_AND,
    OPGEN_OR,
    OPGEN_XOR,
    OPGEN_NOR,
    OPGEN_SLL,
    OPGEN_SRL,
    OPGEN_SRA,
    OPGEN_MULT,
    OPGEN_MULTU,
    OPGEN_DIV,
    OPGEN_DIVU,
    OPGEN_MUL,
    OPGEN_CLZ,
    OPGEN_CLO,
    OPGEN_MFHI,
    OPGEN_MFLO,
    OPGEN_MTHI,
    OPGEN_MTLO,
    OPGEN_J,
    OPGEN_JAL,
    OPGEN_JR,
    OPGEN_JALR,
    OPGEN_BEQ,
    OPGEN_BNE,
    OPGEN_BLEZ,
    OPGEN_BGTZ,
    OPGEN_BLTZ,
    OPGEN_BGEZ,
    OPGEN_BLTZAL,
    OPGEN_BGEZAL,
    OPGEN_MEM,
    OPGEN_CP0
  } opgen_e;

  // bus widths
  localparam int INST_OP_BUS  = 6;
  localparam int REG_ADDR_BUS = 5;

  // primary opcodes
  localparam logic [INST_OP_BUS-1:0] OP_SPECIAL  = 6'h00;
  localparam logic [INST_OP_BUS-1:0] OP_REGIMM   = 6'h01;
  localparam logic [INST_OP_BUS-1:0] OP_J        = 6'h02;
  localparam logic [INST_OP_BUS-1:0] OP_JAL      = 6'h03;
  localparam logic [INST_OP_BUS-1:0] OP_BEQ      = 6'h04;
  localparam logic [INST_OP_BUS-1:0] OP_BNE      = 6'h05;
  localparam logic [INST_OP_BUS-1:0] OP_BLEZ     = 6'h06;
  localparam logic [INST_OP_BUS-1:0] OP_BGTZ     = 6'h07;
  localparam logic [INST_OP_BUS-1:0] OP_ADDI     = 6'h08;
  localparam logic [INST_OP_BUS-1:0] OP_ADDIU    = 6'h09;
  localparam logic [INST_OP_BUS-1:0] OP_SLTI     = 6'h0A;
  localparam logic [INST_OP_BUS-1:0] OP_SLTIU    = 6'h0B;
  localparam logic [INST_OP_BUS-1:0] OP_ANDI     = 6'h0C;
  localparam logic [INST_OP_BUS-1:0] OP_ORI      = 6'h0D;
  localparam logic [INST_OP_BUS-1:0] OP_XORI     = 6'h0E;
  localparam logic [INST_OP_BUS-1:0] OP_LUI      = 6'h0F;
  localparam logic [INST_OP_BUS-1:0] OP_COP0     = 6'h10;
  localparam logic [INST_OP_BUS-1:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [INST_OP_BUS-1:0] OP_LB       = 6'h20;
  localparam logic [INST_OP_BUS-1:0] OP_LH       = 6'h21;
  localparam logic [INST_OP_BUS-1:0] OP_LW       = 6'h23;
  localparam logic [INST_OP_BUS-1:0] OP_LBU      = 6'h24;
  localparam logic [INST_OP_BUS-1:0] OP_LHU      = 6'h25;
  localparam logic [INST_OP_BUS-1:0] OP_SB       = 6'h28;
  localparam logic [INST_OP_BUS-1:0] OP_SH       = 6'h29;
  localparam logic [INST_OP_BUS-1:0] OP_SW       = 6'h2B;

  // SPECIAL funct
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // SPECIAL2 funct
  localparam logic [5:0] FN2_MUL    = 6'h02;
  localparam logic [5:0] FN2_CLZ    = 6'h20;
  localparam logic [5:0] FN2_CLO    = 6'h21;

  // REGIMM rt
  localparam logic [REG_ADDR_BUS-1:0] RT_BLTZ   = 5'h00;
  localparam logic [REG_ADDR_BUS-1:0] RT_BGEZ   = 5'h01;
  localparam logic [REG_ADDR_BUS-1:0] RT_BLTZAL = 5'h10;
  localparam logic [REG_ADDR_BUS-1:0] RT_BGEZAL = 5'h11;

  // COP0 rs and the single CO-format instruction we accept
  localparam logic [REG_ADDR_BUS-1:0] RS_MFC0 = 5'h00;
  localparam logic [REG_ADDR_BUS-1:0] RS_MTC0 = 5'h04;
  localparam logic [31:0]             INST_ERET = 32'h4200_0018;

  function automatic logic [31:0] lane_pc(input logic [31:0] base, input int lane);
    return base + 32'(lane * 4);
  endfunction

endpackage

// File: rtl/opgen_queue_decode.sv
// Per-lane combinational decoder: raw MIPS instruction to opgen code plus a
// reserved-instruction flag for encodings outside the supported set.
module opgen_decode
  import opgen_queue_pkg::*;
(
  input  logic [31:0] inst,
  output opgen_e      opgen,
  output logic        ri
);

  logic [INST_OP_BUS-1:0]  op;
  logic [REG_ADDR_BUS-1:0] rs;
  logic [REG_ADDR_BUS-1:0] rt;
  logic [5:0]              funct;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign funct = inst[5:0];

  always_comb begin
    opgen = OPGEN_NOP;
    ri    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SLLV:     opgen = OPGEN_SLL;
          FN_SRL, FN_SRLV:     opgen = OPGEN_SRL;
          FN_SRA, FN_SRAV:     opgen = OPGEN_SRA;
          FN_JR:               opgen = OPGEN_JR;
          FN_JALR:             opgen = OPGEN_JALR;
          FN_SYSCALL, FN_BREAK: opgen = OPGEN_NOP;
          FN_MFHI:             opgen = OPGEN_MFHI;
          FN_MTHI:             opgen = OPGEN_MTHI;
          FN_MFLO:             opgen = OPGEN_MFLO;
          FN_MTLO:             opgen = OPGEN_MTLO;
          FN_MULT:             opgen = OPGEN_MULT;
          FN_MULTU:            opgen = OPGEN_MULTU;
          FN_DIV:              opgen = OPGEN_DIV;
          FN_DIVU:             opgen = OPGEN_DIVU;
          FN_ADD, FN_ADDU:     opgen = OPGEN_ADD;
          FN_SUB, FN_SUBU:     opgen = OPGEN_SUB;
          FN_AND:              opgen = OPGEN_AND;
          FN_OR:               opgen = OPGEN_OR;
          FN_XOR:              opgen = OPGEN_XOR;
          FN_NOR:              opgen = OPGEN_NOR;
          FN_SLT:              opgen = OPGEN_SLT;
          FN_SLTU:             opgen = OPGEN_SLTU;
          default:             ri    = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          FN2_MUL: opgen = OPGEN_MUL;
          FN2_CLZ: opgen = OPGEN_CLZ;
          FN2_CLO: opgen = OPGEN_CLO;
          default: ri    = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   opgen = OPGEN_BLTZ;
          RT_BGEZ:   opgen = OPGEN_BGEZ;
          RT_BLTZAL: opgen = OPGEN_BLTZAL;
          RT_BGEZAL: opgen = OPGEN_BGEZAL;
          default:   ri    = 1'b1;
        endcase
      end
      OP_COP0: begin
        // ERET must match exactly; every other CO-format word is reserved
        if (inst == INST_ERET) opgen = OPGEN_NOP;
        else if (rs == RS_MFC0 || rs == RS_MTC0) opgen = OPGEN_CP0;
        else ri = 1'b1;
      end
      OP_J:                 opgen = OPGEN_J;
      OP_JAL:               opgen = OPGEN_JAL;
      OP_BEQ:               opgen = OPGEN_BEQ;
      OP_BNE:               opgen = OPGEN_BNE;
      OP_BLEZ:              opgen = OPGEN_BLEZ;
      OP_BGTZ:              opgen = OPGEN_BGTZ;
      OP_ADDI, OP_ADDIU:    opgen = OPGEN_ADD;
      OP_SLTI:              opgen = OPGEN_SLT;
      OP_SLTIU:             opgen = OPGEN_SLTU;
      OP_ANDI:              opgen = OPGEN_AND;
      OP_ORI, OP_LUI:       opgen = OPGEN_OR;
      OP_XORI:              opgen = OPGEN_XOR;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:  opgen = OPGEN_MEM;
      default:              ri    = 1'b1;
    endcase
  end

endmodule

// File: rtl/opgen_queue.sv
// Multi-lane decode buffer: decodes up to WIDTH instructions at enqueue and
// presents up to WIDTH oldest entries to issue from a DEPTH-entry ring.
module opgen_queue
  import opgen_queue_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int PW    = $clog2(DEPTH),
  localparam int OW    = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [CW-1:0]                in_count,
  input  logic [WIDTH*32-1:0]          in_inst,
  input  logic [31:0]                  in_pc,
  output logic                         in_ready,
  output logic [CW-1:0]                out_count,
  output logic [WIDTH*32-1:0]          out_inst,
  output logic [WIDTH*32-1:0]          out_pc,
  output logic [WIDTH*OPGEN_WIDTH-1:0] out_opgen,
  output logic [WIDTH-1:0]             out_ri,
  input  logic [CW-1:0]                deq_count
);

  logic [31:0]      mem_inst  [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  opgen_e           mem_opgen [DEPTH];
  logic [DEPTH-1:0] mem_ri;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ;

  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_n;

  opgen_e        dec_opgen [WIDTH];
  logic [PW-1:0] wr_idx    [WIDTH];
  logic [PW-1:0] rd_idx    [WIDTH];
  logic [WIDTH-1:0] dec_ri;

  // ready looks only at registered occupancy, never at this cycle's dequeue
  assign in_ready  = (occ <= OW'(DEPTH - WIDTH));
  assign out_count = (occ >= OW'(WIDTH)) ? CW'(WIDTH) : occ[CW-1:0];

  always_comb begin
    enq_n = '0;
    if (!flush && in_ready) enq_n = (in_count > CW'(WIDTH)) ? CW'(WIDTH) : in_count;
  end

  always_comb begin
    deq_n = '0;
    if (!flush) deq_n = (deq_count > out_count) ? out_count : deq_count;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic lane_valid;

    opgen_decode u_decode (
      .inst  (in_inst[32*i +: 32]),
      .opgen (dec_opgen[i]),
      .ri    (dec_ri[i])
    );

    assign wr_idx[i]  = tail + PW'(i);
    assign rd_idx[i]  = head + PW'(i);
    assign lane_valid = (CW'(i) < out_count);

    assign out_inst[32*i +: 32]                   = lane_valid ? mem_inst[rd_idx[i]] : '0;
    assign out_pc[32*i +: 32]                     = lane_valid ? mem_pc[rd_idx[i]]   : '0;
    assign out_opgen[OPGEN_WIDTH*i +: OPGEN_WIDTH] = lane_valid ? mem_opgen[rd_idx[i]] : OPGEN_NOP;
    assign out_ri[i]                              = lane_valid & mem_ri[rd_idx[i]];
  end

  // storage needs no reset: lanes past out_count are masked on the read side
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < enq_n) begin
        mem_inst[wr_idx[i]]  <= in_inst[32*i +: 32];
        mem_pc[wr_idx[i]]    <= lane_pc(in_pc, i);
        mem_opgen[wr_idx[i]] <= dec_opgen[i];
        mem_ri[wr_idx[i]]    <= dec_ri[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      tail <= tail + PW'(enq_n);
      head <= head + PW'(deq_n);
      occ  <= occ + OW'(enq_n) - OW'(deq_n);
    end
  end

endmodule

// File: tb/tb_opgen_queue.sv
// Directed and scoreboarded checks for opgen_queue with WIDTH=2, DEPTH=8.
module tb_opgen_queue;
  import opgen_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  in_count = '0;
  logic [63:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic [1:0]  out_count;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [11:0] out_opgen;
  logic [1:0]  out_ri;
  logic [1:0]  deq_count = '0;

  int vectors = 0;
  int errors  = 0;

  opgen_queue #(.WIDTH(2), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_count  (in_count),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_count (out_count),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_opgen (out_opgen),
    .out_ri    (out_ri),
    .deq_count (deq_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && deq_count > out_count) begin
      errors++;
      $display("FAIL deq_guard: deq_count %0d exceeds out_count %0d", deq_count, out_count);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] n, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] pc);
    in_count = n;
    in_inst  = {i1, i0};
    in_pc    = pc;
    step();
    in_count = '0;
    in_inst  = '0;
  endtask

  task automatic test_reset();
    step();
    step();
    vectors++; if (out_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", out_count); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    vectors++; if (out_inst !== 64'h0 || out_pc !== 64'h0 || out_ri !== 2'b00)
      begin errors++; $display("FAIL rst_data: inst %h pc %h ri %b want zeros", out_inst, out_pc, out_ri); end
    vectors++; if (out_opgen !== {OPGEN_NOP, OPGEN_NOP}) begin errors++; $display("FAIL rst_opgen: got %h want NOP", out_opgen); end
    rst = 1'b0;
    enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h0000_1000);
    enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h0000_1008);
    enq(2'd1, 32'h0000_0021, 32'h0000_0000, 32'h0000_1010);
    vectors++; if (out_count !== 2'd2 || out_pc !== {32'h1004, 32'h1000})
      begin errors++; $display("FAIL pre_rst_fill: count %0d pc %h want 2 / 00001004_00001000", out_count, out_pc); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (out_count !== 2'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", out_count); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b want 1", in_ready); end
    vectors++; if (out_pc !== 64'h0) begin errors++; $display("FAIL async_rst_pc: got %h want 0", out_pc); end
    #2 rst = 1'b0;
    step();
    vectors++; if (out_count !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL post_rst_empty: count %0d ready %b want 0/1", out_count, in_ready); end
  endtask

  task automatic test_basic();
    enq(2'd2, 32'h0085_1021, 32'h3C01_1234, 32'hBFC0_0000);
    vectors++; if (out_count !== 2'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", out_count); end
    vectors++; if (out_opgen !== {OPGEN_OR, OPGEN_ADD}) begin errors++; $display("FAIL basic_opgen: got %h want %h", out_opgen, {OPGEN_OR, OPGEN_ADD}); end
    vectors++; if (out_pc !== {32'hBFC0_0004, 32'hBFC0_0000}) begin errors++; $display("FAIL basic_pc: got %h want bfc00004_bfc00000", out_pc); end
    vectors++; if (out_ri !== 2'b00) begin errors++; $display("FAIL basic_ri: got %b want 00", out_ri); end
    vectors++; if (out_inst !== {32'h3C01_1234, 32'h0085_1021}) begin errors++; $display("FAIL basic_inst: got %h want 3c011234_00851021", out_inst); end
    deq_count = 2'd2;
    step();
    deq_count = 2'd0;
    vectors++; if (out_count !== 2'd0 || out_inst !== 64'h0 || out_pc !== 64'h0)
      begin errors++; $display("FAIL basic_drain: count %0d inst %h pc %h want all zero", out_count, out_inst, out_pc); end
    enq(2'd1, 32'h8C01_0000, 32'hFFFF_FFFF, 32'h0000_0300);
    vectors++; if (out_count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", out_count); end
    vectors++; if (out_opgen !== {OPGEN_NOP, OPGEN_MEM}) begin errors++; $display("FAIL single_opgen: got %h want %h", out_opgen, {OPGEN_NOP, OPGEN_MEM}); end
    vectors++; if (out_pc !== {32'h0, 32'h300} || out_inst !== {32'h0, 32'h8C01_0000})
      begin errors++; $display("FAIL single_lane1_mask: pc %h inst %h want lane1 zero", out_pc, out_inst); end
    deq_count = 2'd1;
    step();
    deq_count = 2'd0;
  endtask

  task automatic test_full();
    logic [31:0] exp_pc;
    int drained;
    for (int k = 0; k < 4; k++) enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h100 + 32'(k * 8));
    vectors++; if (in_ready !== 1'b0 || out_count !== 2'd2)
      begin errors++; $display("FAIL full_state: ready %b count %0d want 0/2", in_ready, out_count); end
    enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h0000_0200);
    deq_count = 2'd1;
    step();
    deq_count = 2'd0;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL occ7_ready: got %b want 0", in_ready); end
    vectors++; if (out_pc !== {32'h108, 32'h104}) begin errors++; $display("FAIL occ7_pc: got %h want 00000108_00000104", out_pc); end
    deq_count = 2'd2;
    step();
    deq_count = 2'd0;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL occ5_ready: got %b want 1", in_ready); end
    exp_pc  = 32'h10C;
    drained = 0;
    for (int c = 0; c < 10 && out_count != 2'd0; c++) begin
      vectors++; if (out_pc[31:0] !== exp_pc) begin errors++; $display("FAIL full_drain_pc0: got %h want %h", out_pc[31:0], exp_pc); end
      if (out_count == 2'd2) begin
        vectors++; if (out_pc[63:32] !== exp_pc + 32'd4) begin errors++; $display("FAIL full_drain_pc1: got %h want %h", out_pc[63:32], exp_pc + 32'd4); end
      end
      drained += int'(out_count);
      exp_pc  += 32'(int'(out_count) * 4);
      deq_count = out_count;
      step();
    end
    deq_count = 2'd0;
    vectors++; if (drained != 5) begin errors++; $display("FAIL full_dropped: drained %0d entries want 5", drained); end
  endtask

  task automatic test_wrap();
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] next_pc = 32'h4000_0000;
    logic [31:0] i0, i1;
    int seq = 0;
    int sz, exp_cnt, d, c;
    for (int cyc = 0; cyc < 40; cyc++) begin
      sz = q_pc.size();
      exp_cnt = (sz > 2) ? 2 : sz;
      vectors++; if (int'(out_count) != exp_cnt) begin errors++; $display("FAIL wrap_count: cyc %0d got %0d want %0d", cyc, out_count, exp_cnt); end
      vectors++; if (in_ready !== (sz <= 6)) begin errors++; $display("FAIL wrap_ready: cyc %0d got %b want %b", cyc, in_ready, (sz <= 6)); end
      for (int l = 0; l < exp_cnt; l++) begin
        vectors++; if (out_pc[32*l +: 32] !== q_pc[l]) begin errors++; $display("FAIL wrap_pc: cyc %0d lane %0d got %h want %h", cyc, l, out_pc[32*l +: 32], q_pc[l]); end
        vectors++; if (out_inst[32*l +: 32] !== q_inst[l]) begin errors++; $display("FAIL wrap_inst: cyc %0d lane %0d got %h want %h", cyc, l, out_inst[32*l +: 32], q_inst[l]); end
      end
      if (exp_cnt > 0) begin
        vectors++; if (out_opgen[5:0] !== OPGEN_ADD) begin errors++; $display("FAIL wrap_opgen: cyc %0d got %h want %h", cyc, out_opgen[5:0], OPGEN_ADD); end
      end
      d  = int'($urandom_range(exp_cnt, 0));
      c  = int'($urandom_range(2, 0));
      i0 = 32'h21 | (32'(seq & 31) << 11);
      i1 = 32'h21 | (32'((seq + 1) & 31) << 11);
      deq_count = 2'(d);
      in_count  = 2'(c);
      in_pc     = next_pc;
      in_inst   = {i1, i0};
      for (int k = 0; k < d; k++) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (sz <= 6) begin
        if (c > 0) begin q_pc.push_back(next_pc);        q_inst.push_back(i0); end
        if (c > 1) begin q_pc.push_back(next_pc + 32'd4); q_inst.push_back(i1); end
        next_pc += 32'(c * 4);
        seq     += c;
      end
      step();
    end
    in_count  = '0;
    in_inst   = '0;
    deq_count = '0;
    for (int c2 = 0; c2 < 10 && q_pc.size() > 0; c2++) begin
      exp_cnt = (q_pc.size() > 2) ? 2 : q_pc.size();
      vectors++; if (int'(out_count) != exp_cnt || out_pc[31:0] !== q_pc[0])
        begin errors++; $display("FAIL wrap_drain: count %0d pc %h want %0d / %h", out_count, out_pc[31:0], exp_cnt, q_pc[0]); end
      for (int k = 0; k < exp_cnt; k++) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      deq_count = 2'(exp_cnt);
      step();
    end
    deq_count = '0;
    vectors++; if (out_count !== 2'd0 || q_pc.size() != 0)
      begin errors++; $display("FAIL wrap_empty: dut count %0d model left %0d want 0/0", out_count, q_pc.size()); end
  endtask

  task automatic test_reserved();
    enq(2'd2, 32'hFC00_0000, 32'h0000_000C, 32'h0000_0700);
    vectors++; if (out_ri !== 2'b01) begin errors++; $display("FAIL ri_flags: got %b want 01", out_ri); end
    vectors++; if (out_opgen !== {OPGEN_NOP, OPGEN_NOP}) begin errors++; $display("FAIL ri_opgen: got %h want NOP/NOP", out_opgen); end
    deq_count = 2'd2;
    enq(2'd1, 32'h4200_0018, 32'h0000_0000, 32'h0000_0708);
    deq_count = 2'd0;
    vectors++; if (out_count !== 2'd1 || out_inst[31:0] !== 32'h4200_0018)
      begin errors++; $display("FAIL eret_entry: count %0d inst %h want 1 / 42000018", out_count, out_inst[31:0]); end
    vectors++; if (out_ri !== 2'b00 || out_opgen[5:0] !== OPGEN_NOP)
      begin errors++; $display("FAIL eret_decode: ri %b opgen %h want 00 / NOP", out_ri, out_opgen[5:0]); end
    deq_count = 2'd1;
    enq(2'd2, 32'h4001_6000, 32'h0411_0004, 32'h0000_0710);
    deq_count = 2'd0;
    vectors++; if (out_opgen !== {OPGEN_BGEZAL, OPGEN_CP0} || out_ri !== 2'b00)
      begin errors++; $display("FAIL cp0_regimm: opgen %h ri %b want %h / 00", out_opgen, out_ri, {OPGEN_BGEZAL, OPGEN_CP0}); end
    deq_count = 2'd2;
    step();
    deq_count = 2'd0;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h500 + 32'(k * 8));
    vectors++; if (out_count !== 2'd2 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_pre: count %0d ready %b want 2/1", out_count, in_ready); end
    flush     = 1'b1;
    deq_count = 2'd2;
    enq(2'd2, 32'h0000_0021, 32'h0000_0021, 32'h0000_0600);
    flush     = 1'b0;
    deq_count = 2'd0;
    vectors++; if (out_count !== 2'd0 || in_ready !== 1'b1 || out_pc !== 64'h0)
      begin errors++; $display("FAIL flush_clear: count %0d ready %b pc %h want 0/1/0", out_count, in_ready, out_pc); end
    enq(2'd1, 32'h8C01_0000, 32'h0000_0000, 32'h0000_0900);
    vectors++; if (out_count !== 2'd1 || out_pc[31:0] !== 32'h900)
      begin errors++; $display("FAIL flush_dropped: count %0d pc %h want 1 / 00000900", out_count, out_pc[31:0]); end
    deq_count = 2'd1;
    step();
    deq_count = 2'd0;
    vectors++; if (out_count !== 2'd0) begin errors++; $display("FAIL flush_post_empty: got %0d want 0", out_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_reserved();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
